// File: rtl/spongent_pkg.sv
// Shared constants and types for the Spongent message feeder and its block packer.
package spongent_pkg;
    localparam int SPONGENT_N      = 88;
    localparam int SPONGENT_C      = 80;
    localparam int SPONGENT_R      = 8;
    localparam int SPONGENT_ROUNDS = 45;
    localparam int LCOUNTER_W      = 6;
    localparam logic [LCOUNTER_W-1:0] LCOUNTER_INIT = 6'h05;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ABSORB,
        WAIT_ABS,
        PAD,
        SQUEEZE,
        WAIT_END,
        DONE
    } feeder_state_t;
endpackage

// File: rtl/spongent_msg_feeder_block_packer.sv
// Byte-slot block register with the slot counter; bytes land MSB first and a
// short final block is filled with the 0x80/zeros pad in the same cycle.
module block_packer
    import spongent_pkg::*;
#(
    parameter int r = SPONGENT_R
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_wr,
    input  logic         i_last,
    input  logic [7:0]   i_byte,
    input  logic         i_load_pad,
    output logic [r-1:0] o_block,
    output logic         o_bcnt_last
);
    localparam int NB = r / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [r-1:0]  r_block;
    logic [r-1:0]  w_block;
    logic [CW-1:0] r_bcnt;
    logic          w_bcnt_last;

    assign w_bcnt_last = (int'(r_bcnt) == NB - 1);
    assign o_bcnt_last = w_bcnt_last;
    assign o_block     = r_block;

    always_comb begin
        w_block = r_block;
        if (i_load_pad) begin
            w_block = '0;
            w_block[r-1 -: 8] = PAD_BYTE;
        end else if (i_wr) begin
            for (int s = 0; s < NB; s++) begin
                if (s == int'(r_bcnt)) begin
                    w_block[r-1-8*s -: 8] = i_byte;
                end else if (i_last && (s == int'(r_bcnt) + 1)) begin
                    w_block[r-1-8*s -: 8] = PAD_BYTE;
                end else if (i_last && (s > int'(r_bcnt) + 1)) begin
                    w_block[r-1-8*s -: 8] = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_block <= '0;
            r_bcnt  <= '0;
        end else begin
            r_block <= w_block;
            if (i_clr) begin
                r_bcnt <= '0;
            end else if (i_wr && !w_bcnt_last) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spongent_msg_feeder.sv
// Framing stage in front of the iterative Spongent core: packs bytes into
// rate blocks, pads, sequences absorb/squeeze pulses and captures the digest.
module spongent_msg_feeder
    import spongent_pkg::*;
#(
    parameter int N = SPONGENT_N,
    parameter int r = SPONGENT_R
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   i_in_data,
    input  logic         i_in_valid,
    input  logic         i_in_last,
    output logic         o_in_ready,
    output logic [r-1:0] o_core_data,
    output logic         o_core_data_ready,
    output logic         o_core_start_hash,
    input  logic         i_core_busy,
    input  logic         i_core_end_hash,
    input  logic [N-1:0] i_core_digest,
    output logic [N-1:0] o_digest,
    output logic         o_digest_valid,
    output logic         o_busy
);
    feeder_state_t r_state;
    feeder_state_t w_next;
    logic          r_padded;
    logic          r_last_seen;
    logic          r_abs_first;
    logic          r_data_ready;
    logic          r_start_hash;
    logic          r_busy;
    logic [N-1:0]  r_digest;
    logic          r_digest_valid;
    logic          w_wr;
    logic          w_clr;
    logic          w_load_pad;
    logic          w_capture;
    logic          w_bcnt_last;

    block_packer #(.r(r)) u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_clr),
        .i_wr        (w_wr),
        .i_last      (i_in_last),
        .i_byte      (i_in_data),
        .i_load_pad  (w_load_pad),
        .o_block     (o_core_data),
        .o_bcnt_last (w_bcnt_last)
    );

    assign o_in_ready        = (r_state == IDLE) || (r_state == COLLECT) || (r_state == DONE);
    assign o_core_data_ready = r_data_ready;
    assign o_core_start_hash = r_start_hash;
    assign o_digest          = r_digest;
    assign o_digest_valid    = r_digest_valid;
    assign o_busy            = r_busy;

    always_comb begin
        w_next     = r_state;
        w_wr       = 1'b0;
        w_clr      = 1'b0;
        w_load_pad = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE, COLLECT, DONE: begin
                if (i_in_valid) begin
                    w_wr   = 1'b1;
                    w_next = (i_in_last || w_bcnt_last) ? ABSORB : COLLECT;
                end
            end
            ABSORB: w_next = WAIT_ABS;
            WAIT_ABS: begin
                // the core only raises busy the cycle after the pulse, so skip that sample
                if (!r_abs_first && !i_core_busy) begin
                    w_clr = 1'b1;
                    if (r_padded)         w_next = SQUEEZE;
                    else if (r_last_seen) w_next = PAD;
                    else                  w_next = COLLECT;
                end
            end
            PAD: begin
                w_load_pad = 1'b1;
                w_next     = ABSORB;
            end
            SQUEEZE: w_next = WAIT_END;
            WAIT_END: begin
                if (i_core_end_hash) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_padded       <= 1'b0;
            r_last_seen    <= 1'b0;
            r_abs_first    <= 1'b0;
            r_data_ready   <= 1'b0;
            r_start_hash   <= 1'b0;
            r_busy         <= 1'b0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_abs_first  <= (r_state == ABSORB);
            r_data_ready <= (w_next == ABSORB);
            r_start_hash <= (w_next == SQUEEZE);
            r_busy       <= !((w_next == IDLE) || (w_next == DONE));
            if (w_wr) begin
                r_padded       <= i_in_last && !w_bcnt_last;
                r_last_seen    <= i_in_last;
                r_digest_valid <= 1'b0;
            end
            if (w_load_pad) begin
                r_padded <= 1'b1;
            end
            if (w_capture) begin
                r_digest       <= i_core_digest;
                r_digest_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spongent_msg_feeder.sv
// Directed bench: an r=8 and an r=16 feeder, each driving a small behavioural
// core stub that logs absorbed blocks and answers squeeze with a fixed digest.
module tb_spongent_msg_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vecs = 0;
    int   errs = 0;

    logic [7:0]  a_data, a_cd;
    logic        a_valid, a_last, a_ready, a_dr, a_sh, a_cbusy, a_cend, a_dv, a_bsy;
    logic [87:0] a_dig, a_digo;
    int          a_blen, a_bcyc, a_ecyc, a_base, a_sh0;
    int          a_shn = 0;
    logic [7:0]  a_blocks[$];

    logic [7:0]  b_data;
    logic [15:0] b_cd;
    logic        b_valid, b_last, b_ready, b_dr, b_sh, b_cbusy, b_cend, b_dv, b_bsy;
    logic [87:0] b_dig, b_digo, b_old;
    int          b_blen, b_bcyc, b_ecyc, b_base, b_sh0;
    int          b_shn = 0;
    logic [15:0] b_blocks[$];

    spongent_msg_feeder #(.N(88), .r(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_in_data(a_data), .i_in_valid(a_valid), .i_in_last(a_last),
        .o_in_ready(a_ready), .o_core_data(a_cd), .o_core_data_ready(a_dr), .o_core_start_hash(a_sh),
        .i_core_busy(a_cbusy), .i_core_end_hash(a_cend), .i_core_digest(a_dig),
        .o_digest(a_digo), .o_digest_valid(a_dv), .o_busy(a_bsy)
    );

    spongent_msg_feeder #(.N(88), .r(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_in_data(b_data), .i_in_valid(b_valid), .i_in_last(b_last),
        .o_in_ready(b_ready), .o_core_data(b_cd), .o_core_data_ready(b_dr), .o_core_start_hash(b_sh),
        .i_core_busy(b_cbusy), .i_core_end_hash(b_cend), .i_core_digest(b_dig),
        .o_digest(b_digo), .o_digest_valid(b_dv), .o_busy(b_bsy)
    );

    // core stubs: busy for *_blen cycles after each absorb, end_hash 4 cycles after start
    always @(posedge clk) begin
        if (rst) begin
            a_cbusy <= 1'b0; a_bcyc <= 0; a_cend <= 1'b0; a_ecyc <= 0;
        end else begin
            a_cend <= 1'b0;
            if (a_dr) begin a_blocks.push_back(a_cd); a_cbusy <= 1'b1; a_bcyc <= a_blen; end
            else if (a_bcyc > 1) a_bcyc <= a_bcyc - 1;
            else begin a_cbusy <= 1'b0; a_bcyc <= 0; end
            if (a_sh) begin a_shn <= a_shn + 1; a_ecyc <= 4; end
            else if (a_ecyc == 1) begin a_cend <= 1'b1; a_ecyc <= 0; end
            else if (a_ecyc > 1) a_ecyc <= a_ecyc - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_cbusy <= 1'b0; b_bcyc <= 0; b_cend <= 1'b0; b_ecyc <= 0;
        end else begin
            b_cend <= 1'b0;
            if (b_dr) begin b_blocks.push_back(b_cd); b_cbusy <= 1'b1; b_bcyc <= b_blen; end
            else if (b_bcyc > 1) b_bcyc <= b_bcyc - 1;
            else begin b_cbusy <= 1'b0; b_bcyc <= 0; end
            if (b_sh) begin b_shn <= b_shn + 1; b_ecyc <= 4; end
            else if (b_ecyc == 1) begin b_cend <= 1'b1; b_ecyc <= 0; end
            else if (b_ecyc > 1) b_ecyc <= b_ecyc - 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_send(input logic [7:0] d, input logic l);
        int k;
        a_data = d; a_last = l; a_valid = 1'b1;
        k = 0;
        while (!a_ready && k < 200) begin @(negedge clk); k++; end
        chk("a_send_ready", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d, input logic l);
        int k;
        b_data = d; b_last = l; b_valid = 1'b1;
        k = 0;
        while (!b_ready && k < 200) begin @(negedge clk); k++; end
        chk("b_send_ready", b_ready, 1'b1);
        @(negedge clk);
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic a_wait_dv();
        int k;
        k = 0;
        while (!a_dv && k < 300) begin @(negedge clk); k++; end
        chk("a_dv_set", a_dv, 1'b1);
    endtask

    task automatic b_wait_dv();
        int k;
        k = 0;
        while (!b_dv && k < 300) begin @(negedge clk); k++; end
        chk("b_dv_set", b_dv, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        a_data = 8'h00; a_valid = 1'b0; a_last = 1'b0; a_blen = 2;
        b_data = 8'h00; b_valid = 1'b0; b_last = 1'b0; b_blen = 2;
        a_dig = 88'h0123456789ABCDEF012345;
        b_dig = 88'hFEDCBA9876543210FEDCBA;
        repeat (3) @(negedge clk);

        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_a_cd", a_cd, 8'h00);
        chk("rst_a_dr", a_dr, 1'b0);
        chk("rst_a_sh", a_sh, 1'b0);
        chk("rst_a_digest", a_digo, 88'h0);
        chk("rst_a_dv", a_dv, 1'b0);
        chk("rst_a_busy", a_bsy, 1'b0);
        chk("rst_b_ready", b_ready, 1'b1);
        chk("rst_b_cd", b_cd, 16'h0000);
        chk("rst_b_busy", b_bsy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // r=8, "A": 0x41 then pad block 0x80
        a_base = a_blocks.size(); a_sh0 = a_shn;
        a_send(8'h41, 1'b1);
        chk("a_dr_t1", a_dr, 1'b1);
        chk("a_cd_t1", a_cd, 8'h41);
        chk("a_ready_absorb", a_ready, 1'b0);
        chk("a_busy_msg", a_bsy, 1'b1);
        a_wait_dv();
        chk("a_nblk", a_blocks.size() - a_base, 2);
        chk("a_blk0", a_blocks[a_base], 8'h41);
        chk("a_blk1", a_blocks[a_base+1], 8'h80);
        chk("a_starts", a_shn - a_sh0, 1);
        chk("a_digest", a_digo, 88'h0123456789ABCDEF012345);
        chk("a_busy_done", a_bsy, 1'b0);
        chk("a_ready_done", a_ready, 1'b1);

        // r=16, {12,34,56}: 0x1234, 0x5680, no extra pad block
        b_base = b_blocks.size(); b_sh0 = b_shn;
        b_send(8'h12, 1'b0);
        chk("b_ready_collect", b_ready, 1'b1);
        b_send(8'h34, 1'b0);
        chk("b_dr_t1", b_dr, 1'b1);
        chk("b_cd_t1", b_cd, 16'h1234);
        b_send(8'h56, 1'b1);
        b_wait_dv();
        chk("b1_nblk", b_blocks.size() - b_base, 2);
        chk("b1_blk0", b_blocks[b_base], 16'h1234);
        chk("b1_blk1", b_blocks[b_base+1], 16'h5680);
        chk("b1_starts", b_shn - b_sh0, 1);
        chk("b1_digest", b_digo, 88'hFEDCBA9876543210FEDCBA);

        // back-to-back: digest held in DONE, cleared by first byte of next message
        b_old = b_dig;
        b_dig = 88'h00112233445566778899AA;
        repeat (3) @(negedge clk);
        chk("b_digest_held", b_digo, b_old);
        chk("b_dv_held", b_dv, 1'b1);
        b_base = b_blocks.size(); b_sh0 = b_shn;
        b_send(8'hAB, 1'b0);
        chk("b_dv_clr", b_dv, 1'b0);
        b_send(8'hCD, 1'b1);
        b_wait_dv();
        chk("b2_nblk", b_blocks.size() - b_base, 2);
        chk("b2_blk0", b_blocks[b_base], 16'hABCD);
        chk("b2_blk1", b_blocks[b_base+1], 16'h8000);
        chk("b2_starts", b_shn - b_sh0, 1);
        chk("b2_digest", b_digo, 88'h00112233445566778899AA);

        // long core busy with a byte waiting: nothing dropped
        b_blen = 50;
        b_base = b_blocks.size(); b_sh0 = b_shn;
        b_send(8'h11, 1'b0);
        b_send(8'h22, 1'b0);
        b_data = 8'h33; b_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_ready_held_low", b_ready, 1'b0);
        chk("b_core_busy_high", b_cbusy, 1'b1);
        b_send(8'h33, 1'b0);
        b_send(8'h44, 1'b1);
        b_wait_dv();
        chk("b3_nblk", b_blocks.size() - b_base, 3);
        chk("b3_blk0", b_blocks[b_base], 16'h1122);
        chk("b3_blk1", b_blocks[b_base+1], 16'h3344);
        chk("b3_blk2", b_blocks[b_base+2], 16'h8000);
        chk("b3_starts", b_shn - b_sh0, 1);

        // reset while waiting on the core, then a fresh message {0x00}
        a_blen = 20;
        a_send(8'h55, 1'b0);
        repeat (2) @(negedge clk);
        chk("a_busy_wait_abs", a_bsy, 1'b1);
        chk("a_ready_wait_abs", a_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", a_ready, 1'b1);
        chk("mid_rst_dr", a_dr, 1'b0);
        chk("mid_rst_sh", a_sh, 1'b0);
        chk("mid_rst_cd", a_cd, 8'h00);
        chk("mid_rst_digest", a_digo, 88'h0);
        chk("mid_rst_dv", a_dv, 1'b0);
        chk("mid_rst_busy", a_bsy, 1'b0);
        a_blen = 2;
        a_dig = 88'hA5A5A5A5A5A5A5A5A5A5A5;
        a_base = a_blocks.size(); a_sh0 = a_shn;
        a_send(8'h00, 1'b1);
        a_wait_dv();
        chk("a2_nblk", a_blocks.size() - a_base, 2);
        chk("a2_blk0", a_blocks[a_base], 8'h00);
        chk("a2_blk1", a_blocks[a_base+1], 8'h80);
        chk("a2_starts", a_shn - a_sh0, 1);
        chk("a2_digest", a_digo, 88'hA5A5A5A5A5A5A5A5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/spongent_msg_feeder.md
# spongent_msg_feeder

Upstream framing stage for the iterative Spongent hash core. It accepts a message as a byte stream with a valid/ready/last handshake and packs the bytes into r-bit blocks. It applies Spongent padding (a single 1 bit, then zeros up to a block boundary) and pulses the core's `data_ready` once per absorbed block. After the last block it pulses `start_hash`, then captures the N-bit digest when the core reports `end_hash`.

## Interface
- `N`, 88: digest width; must equal the core's N.
- `r`, 8: block (rate) width; must be a multiple of 8, at least 8.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: message byte.
- `in_valid` input 1: `in_data` is valid.
- `in_last` input 1: final byte of the message; qualified by `in_valid`.
- `in_ready` output 1: the feeder accepts a byte this cycle.
- `core_data` output r: block presented to the core's `data_input`.
- `core_data_ready` output 1: one-cycle absorb pulse to the core.
- `core_start_hash` output 1: one-cycle squeeze-start pulse to the core.
- `core_busy` input 1: core busy.
- `core_end_hash` input 1: core digest valid.
- `core_digest` input N: core digest.
- `digest_o` output N: registered digest.
- `digest_valid` output 1: `digest_o` holds the result of the last message; level signal.
- `busy_o` output 1: a message is in progress (state is not IDLE or DONE).

## Operation
- State machine states: IDLE, COLLECT, ABSORB, WAIT_ABS, PAD, SQUEEZE, WAIT_END, DONE.
- Packing: the first byte of a block goes in `core_data[r-1:r-8]` (MSB first). A byte counter `bcnt` (0..r/8-1) selects the slot.
- IDLE/COLLECT:
  - `in_ready`=1.
  - On `in_valid`: write the byte at slot `bcnt` and increment `bcnt`. Any accepted byte moves IDLE to COLLECT and clears `digest_valid`.
  - Block complete (`bcnt`==r/8-1): go to ABSORB and remember `last_seen`=`in_last`.
  - `in_last` on a non-final slot: write 0x80 at slot `bcnt`+1, zero the remaining slots, and set `padded`=1. Go to ABSORB.
- ABSORB: `core_data_ready`=1 for exactly one cycle, with `core_data` stable. Next state is WAIT_ABS.
- WAIT_ABS: the cycle after the pulse is ignored (the core raises busy then). After that, wait for `core_busy`==0. Then:
  - `padded`: go to SQUEEZE.
  - `last_seen` and not `padded`: go to PAD.
  - Otherwise: clear `bcnt` and return to COLLECT.
- PAD: the message length is a multiple of r/8. Load the block 0x80 followed by zeros, set `padded`=1, and go to ABSORB.
- SQUEEZE: `core_start_hash`=1 for exactly one cycle. Go to WAIT_END.
- WAIT_END: on `core_end_hash`=1, register `core_digest` into `digest_o`, set `digest_valid`=1, and go to DONE.
- DONE:
  - `in_ready`=1.
  - An accepted byte is handled exactly as in IDLE (it clears `digest_valid` and moves to COLLECT).
  - The state is held indefinitely otherwise.
- `in_ready`=0 in ABSORB, WAIT_ABS, PAD, SQUEEZE and WAIT_END; no byte is dropped.
- Empty messages are not supported; a message has at least one byte.

## Timing
- Reset values:
  - State is IDLE; `bcnt`=0; `padded`=0; `last_seen`=0.
  - `in_ready`=1; `core_data`=0; `core_data_ready`=0; `core_start_hash`=0.
  - `digest_o`=0; `digest_valid`=0; `busy_o`=0.
- All outputs are registered except `in_ready`, which is decoded from state.
- Reset mid-operation returns the feeder to IDLE within one cycle. The top level resets the core with the same `rst`.
- Block-completing byte accepted at cycle t: `core_data_ready` is high at t+1. `core_busy` is first sampled at t+3.
- `core_end_hash` at cycle t: `digest_o` and `digest_valid` are updated at t+1.
- `core_data_ready` and `core_start_hash` are never high in the same cycle and never repeat without an intervening busy-low check.
- A `core_end_hash` seen outside WAIT_END is ignored.

## Structure
- Shared package `spongent_pkg`:
  - Parameter defaults (N, c, r, R, lCounter constants).
  - The state enum `feeder_state_t`.
  - The `PAD_BYTE`=8'h80 constant.
- One sub-module, `block_packer`: the byte-slot register plus the `bcnt` counter and pad-fill logic. The FSM stays in `spongent_msg_feeder`.

## Test plan
- r=8, message {0x41} with last: one absorb of 0x41, then an absorb of 0x80, then one `start_hash`. `digest_o` matches the core model for "A".
- r=16, message {0x12,0x34,0x56} with last on 0x56: blocks 0x1234, then 0x5680, then `start_hash`. No extra pad block.
- r=16, message {0xAB,0xCD} with last: blocks 0xABCD, then 0x8000.
- `core_busy` held high 50 cycles after an absorb while `in_valid`=1: `in_ready` stays 0, no byte is lost, and the next block is correct.
- `rst` asserted in WAIT_ABS: the next cycle is IDLE with all outputs at reset values. A fresh message {0x00} yields the correct digest.
- Two back-to-back messages: `digest_valid` clears on the first byte of message 2 and sets again with the new digest. The first digest is held until then.
